alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU (add / equality compare) between two requesters with
//  round-robin fairness. Each operation runs over registered operands. The result is
//  returned on one shared response channel with valid/ready backpressure.
//  Sits between two issuing units and the ALU instance. Drives the ALU ctrl/op inputs
//  and captures the ALU result and EQ outputs.
// PARAMETERS
//  DATA_WIDTH  8   operand/result width; must match the ALU instance
//  CTRLSIG     1   ALU control width; 0 = add, 1 = equality compare
//  CNT_WIDTH   16  width of grant counters (ALU_ARB_STATS_EN only)
// PORTS
//  clk         in   1           single clock; all state updates on rising edge
//  rst         in   1           reset, synchronous, active-high
//  req_valid   in   2           per-requester request valid (bit i = requester i)
//  req_ready   out  2           per-requester accept; one-hot or zero
//  req0_ctrl   in   CTRLSIG     requester 0 opcode
//  req0_op1    in   DATA_WIDTH  requester 0 operand 1
//  req0_op2    in   DATA_WIDTH  requester 0 operand 2
//  req1_ctrl   in   CTRLSIG     requester 1 opcode
//  req1_op1    in   DATA_WIDTH  requester 1 operand 1
//  req1_op2    in   DATA_WIDTH  requester 1 operand 2
//  alu_ctrl    out  CTRLSIG     to ALU ALUctrl
//  alu_op1     out  DATA_WIDTH  to ALU ALUop1
//  alu_op2     out  DATA_WIDTH  to ALU ALUop2
//  alu_out     in   DATA_WIDTH  from ALU ALUout
//  alu_eq      in   1           from ALU EQ
//  resp_valid  out  1           response valid
//  resp_ready  in   1           response accept
//  resp_id     out  1           requester that owns the response
//  resp_out    out  DATA_WIDTH  captured ALU result
//  resp_eq     out  1           captured ALU EQ
// BEHAVIOUR
//  - Reset values: state=IDLE; all registers = 0; resp_valid=0; req_ready=0.
//    alu_ctrl/op1/op2=0; last_grant=1, so requester 0 wins first.
//    While rst=1, req_ready is forced to 0.
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE state:
//    - req_ready is combinational and asserted only toward the grant.
//    - Grant rule: if exactly one req_valid is high, grant it. If both are high,
//      grant the requester != last_grant.
//    - On valid & ready, latch ctrl/op1/op2 into the operand regs, set id and
//      last_grant to the grant, then go to EXEC.
//  - EXEC state (1 cycle):
//    - The operand regs drive alu_* for the whole cycle.
//    - alu_out/alu_eq are captured into resp_out/resp_eq at the end of the cycle.
//    - Then go to RESP.
//  - RESP state:
//    - resp_valid=1; resp_id/out/eq are held stable until resp_ready=1.
//    - On the handshake, go to IDLE.
//    - req_ready stays 0 in EXEC and RESP.
//  - Timing: accept edge at cycle N; resp_valid is high from cycle N+2.
//    Minimum issue interval is 3 cycles.
//  - Outside EXEC, alu_* keep the last operands; they are never X.
//  - Arithmetic: add wraps modulo 2^DATA_WIDTH.
//    For ctrl=1, resp_out=0 and resp_eq=(op1==op2). For ctrl=0, resp_eq=0.
//  - Requesters hold valid and payload stable until ready. A valid dropped without
//    ready is ignored.
//  - If rst is asserted mid-operation (EXEC or RESP), the transaction is dropped and
//    no response is issued.
// CONFIGURATION
//  - ALU_ARB_STATS_EN defined:
//    - Adds outputs grant_cnt0 and grant_cnt1 [CNT_WIDTH-1:0], reset to 0.
//    - The counter for the accepted requester increments on each request handshake.
//    - Counters saturate at all-ones.
//  - ALU_ARB_STATS_EN undefined: no counter logic and no counter ports.
// STRUCTURE
//  - Package alu_arb_pkg:
//    - typedef enum arb_state_t {IDLE, EXEC, RESP}
//    - localparams ALU_ADD=1'b0, ALU_EQ=1'b1
//  - Sub-module rr_arb2: 2-way round-robin grant.
//    Inputs req[1:0] and last; output gnt[1:0], one-hot or zero.
//  - The ALU is instantiated by the parent, not inside this block.
// TESTING
//  1. rst=1 for 2 cycles, then 0 with no requests.
//     -> resp_valid=0, req_ready=00, alu_op1/op2=0.
//  2. req0: ctrl=0, 5, 3; resp_ready=1.
//     -> resp_valid at accept+2; resp_id=0, resp_out=8, resp_eq=0.
//  3. req1: ctrl=1, 7, 7.
//     -> resp_out=0, resp_eq=1, resp_id=1.
//     Then req1: ctrl=1, 7, 6 -> resp_eq=0.
//  4. Both req_valid held high for 4 ops.
//     -> grants in order 0,1,0,1; each resp_id matches its grant.
//  5. req0: 200+100 with resp_ready=0 for 4 cycles.
//     -> resp_out=44 held stable; req_ready=00 throughout; accepted when ready=1.
//  6. rst during EXEC -> no response; the next req0 is accepted normally.
//     With ALU_ARB_STATS_EN and CNT_WIDTH=2: 5 grants to req0 -> grant_cnt0=3.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and opcodes for the two-requester ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_EQ  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright; on contention the
// requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Grant is one-hot or zero; contention resolves away from the last winner
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU (add / equality compare) between two
// requesters with round-robin fairness and returns results on a single
// valid/ready response channel.
// Optional feature: define ALU_ARB_STATS_EN to add saturating per-requester
// grant counters (grant_cnt0 / grant_cnt1).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CTRLSIG    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [CTRLSIG-1:0]    req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic [CTRLSIG-1:0]    req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    output logic [CTRLSIG-1:0]    alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_eq,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_out,
    output logic                  resp_eq
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1
`endif
);

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("alu_arbiter: CNT_WIDTH must be at least 1");
    end

    arb_state_t            r_state;
    logic                  r_last;
    logic [CTRLSIG-1:0]    r_ctrl;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic                  r_id;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_eq;

    logic [1:0]            w_gnt;
    logic                  w_sel;
    logic                  w_accept;
    logic                  w_is_add;
    logic                  w_is_eq;

    rr_arb2 u_rr_arb2 (
        .req  (req_valid),
        .last (r_last),
        .gnt  (w_gnt)
    );

    // Ready only toward the grant, only while idle, never during reset
    assign req_ready = ((r_state == IDLE) && !rst) ? w_gnt : 2'b00;
    assign w_sel     = w_gnt[1];
    assign w_accept  = |(req_valid & req_ready);

    // Opcodes outside add/compare return zero result and clear EQ
    assign w_is_add  = (r_ctrl == CTRLSIG'(ALU_ADD));
    assign w_is_eq   = (r_ctrl == CTRLSIG'(ALU_EQ));

    assign alu_ctrl   = r_ctrl;
    assign alu_op1    = r_op1;
    assign alu_op2    = r_op2;
    assign resp_valid = (r_state == RESP);
    assign resp_id    = r_id;
    assign resp_out   = r_out;
    assign resp_eq    = r_eq;

    // Control FSM with operand latch on accept and result capture at end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_ctrl  <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_id    <= 1'b0;
            r_out   <= '0;
            r_eq    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= EXEC;
                        r_id    <= w_sel;
                        r_last  <= w_sel;
                        r_ctrl  <= w_sel ? req1_ctrl : req0_ctrl;
                        r_op1   <= w_sel ? req1_op1  : req0_op1;
                        r_op2   <= w_sel ? req1_op2  : req0_op2;
                    end
                end
                EXEC: begin
                    r_out   <= w_is_add ? alu_out : '0;
                    r_eq    <= w_is_eq & alu_eq;
                    r_state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] r_cnt0;
    logic [CNT_WIDTH-1:0] r_cnt1;

    // Per-requester grant counters, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (!w_sel && (r_cnt0 != '1)) begin
                r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
            end
            if (w_sel && (r_cnt1 != '1)) begin
                r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
            end
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected responses on
// accept, an independent negedge monitor checks handshakes, grants, latency,
// hold-stability and (with ALU_ARB_STATS_EN) the grant counters.
module tb_alu_arbiter;

    localparam int DW  = 8;
    localparam int CW  = 1;
    localparam int CNW = 2;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } op_t;

    typedef struct {
        logic          id;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [DW-1:0] out;
        logic          eq;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [CW-1:0] req0_ctrl, req1_ctrl;
    logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [CW-1:0] alu_ctrl;
    logic [DW-1:0] alu_op1, alu_op2, alu_out;
    logic          alu_eq;
    logic          resp_valid, resp_ready, resp_id, resp_eq;
    logic [DW-1:0] resp_out;
`ifdef ALU_ARB_STATS_EN
    logic [CNW-1:0] grant_cnt0, grant_cnt1;
`endif

    int total = 0;
    int bad   = 0;

    exp_t sb[$];
    op_t  q0[$];
    op_t  q1[$];

    alu_arbiter #(
        .DATA_WIDTH (DW),
        .CTRLSIG    (CW),
        .CNT_WIDTH  (CNW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req1_ctrl  (req1_ctrl),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .alu_ctrl   (alu_ctrl),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_out    (alu_out),
        .alu_eq     (alu_eq),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_out   (resp_out),
        .resp_eq    (resp_eq)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    // Behavioural ALU stand-in for the parent's instance
    assign alu_out = (alu_ctrl == 1'b1) ? 8'd0 : DW'(alu_op1 + alu_op2);
    assign alu_eq  = (alu_ctrl == 1'b1) && (alu_op1 == alu_op2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference arbitration rule: lone requester wins, contention goes to the other one
    function automatic logic [1:0] ref_grant(input logic [1:0] v, input logic last);
        int winner;
        if (v == 2'b00) return 2'b00;
        if (v == 2'b11) winner = last ? 0 : 1;
        else            winner = v[1] ? 1 : 0;
        return (winner == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic exp_t ref_resp(input logic id, input op_t o);
        exp_t e;
        e.id   = id;
        e.ctrl = o.ctrl;
        e.op1  = o.op1;
        e.op2  = o.op2;
        if (o.ctrl == 1'b1) begin
            e.out = '0;
            e.eq  = (o.op1 == o.op2);
        end else begin
            e.out = DW'((int'(o.op1) + int'(o.op2)) % 256);
            e.eq  = 1'b0;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic          m_last = 1'b1;
    logic          age_run = 1'b0;
    int            age = 0;
    logic          prev_hold = 1'b0;
    exp_t          held;
    int            m_cnt0 = 0;
    int            m_cnt1 = 0;

    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        logic       busy;
        logic       exp_vld;
        if (rst) begin
            chk("ready_in_rst", 32'(req_ready), 32'd0);
            m_last    = 1'b1;
            age_run   = 1'b0;
            age       = 0;
            prev_hold = 1'b0;
            m_cnt0    = 0;
            m_cnt1    = 0;
        end else begin
            if (age_run) age++;
            busy    = age_run || (sb.size() > 0);
            exp_rdy = busy ? 2'b00 : ref_grant(req_valid, m_last);
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            exp_vld = age_run && (age >= 2);
            chk("resp_valid", 32'(resp_valid), 32'(exp_vld));
`ifdef ALU_ARB_STATS_EN
            chk("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
            chk("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
`endif
            if (sb.size() > 0) begin
                chk("alu_ctrl", 32'(alu_ctrl), 32'(sb[0].ctrl));
                chk("alu_op1", 32'(alu_op1), 32'(sb[0].op1));
                chk("alu_op2", 32'(alu_op2), 32'(sb[0].op2));
            end
            if (prev_hold) begin
                chk("hold_id", 32'(resp_id), 32'(held.id));
                chk("hold_out", 32'(resp_out), 32'(held.out));
                chk("hold_eq", 32'(resp_eq), 32'(held.eq));
            end
            prev_hold = 1'b0;
            if (exp_vld && resp_valid && (sb.size() > 0)) begin
                chk("resp_id", 32'(resp_id), 32'(sb[0].id));
                chk("resp_out", 32'(resp_out), 32'(sb[0].out));
                chk("resp_eq", 32'(resp_eq), 32'(sb[0].eq));
                if (resp_ready) begin
                    void'(sb.pop_front());
                    age_run = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    held      = sb[0];
                end
            end
            if (!busy && ((exp_rdy & req_valid) != 2'b00)) begin
                m_last  = exp_rdy[1];
                age_run = 1'b1;
                age     = 0;
                if (exp_rdy[1]) m_cnt1 = (m_cnt1 < (1 << CNW) - 1) ? m_cnt1 + 1 : m_cnt1;
                else            m_cnt0 = (m_cnt0 < (1 << CNW) - 1) ? m_cnt0 + 1 : m_cnt0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // mode 0: eager valids, resp_ready=1; mode 1: random; mode 2: resp_ready low early
    task automatic run(input int mode);
        int         cyc;
        logic [1:0] hs;
        cyc = 0;
        while (1) begin
            req_valid[0] = (q0.size() > 0) && (req_valid[0] || (mode != 1) || ($urandom_range(0, 1) == 1));
            req_valid[1] = (q1.size() > 0) && (req_valid[1] || (mode != 1) || ($urandom_range(0, 1) == 1));
            if (q0.size() > 0) begin
                req0_ctrl = q0[0].ctrl; req0_op1 = q0[0].op1; req0_op2 = q0[0].op2;
            end
            if (q1.size() > 0) begin
                req1_ctrl = q1[0].ctrl; req1_op1 = q1[0].op1; req1_op2 = q1[0].op2;
            end
            case (mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = ($urandom_range(0, 2) != 0);
                default: resp_ready = (cyc >= 6);
            endcase
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (hs[0]) begin
                sb.push_back(ref_resp(1'b0, q0[0]));
                void'(q0.pop_front());
                req_valid[0] = 1'b0;
            end
            if (hs[1]) begin
                sb.push_back(ref_resp(1'b1, q1[0]));
                void'(q1.pop_front());
                req_valid[1] = 1'b0;
            end
            cyc++;
            if ((q0.size() == 0) && (q1.size() == 0) && (sb.size() == 0)) break;
            if (cyc > 600) begin
                chk("run_timeout", 32'(cyc), 32'd0);
                q0.delete();
                q1.delete();
                break;
            end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        int   waited;
        op_t  o;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req0_ctrl  = '0; req0_op1 = '0; req0_op2 = '0;
        req1_ctrl  = '0; req1_op1 = '0; req1_op2 = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        #2;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_alu_op1", 32'(alu_op1), 32'd0);
        chk("rst_alu_op2", 32'(alu_op2), 32'd0);
        @(posedge clk);
        #1;

        // Add, then two compares
        q0.push_back('{1'b0, 8'd5, 8'd3});
        run(0);
        q1.push_back('{1'b1, 8'd7, 8'd7});
        q1.push_back('{1'b1, 8'd7, 8'd6});
        run(0);

        // Contention: grants must alternate 0,1,0,1
        q0.push_back('{1'b0, 8'd1, 8'd2});
        q0.push_back('{1'b0, 8'd3, 8'd4});
        q1.push_back('{1'b1, 8'd9, 8'd9});
        q1.push_back('{1'b0, 8'd10, 8'd20});
        run(0);

        // Wrapping add under response backpressure
        q0.push_back('{1'b0, 8'd200, 8'd100});
        run(2);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            o.ctrl = CW'($urandom_range(0, 1));
            o.op1  = DW'($urandom_range(0, 255));
            o.op2  = ($urandom_range(0, 3) == 0) ? o.op1 : DW'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) q1.push_back(o);
            else                           q0.push_back(o);
        end
        run(1);

        // Reset during EXEC drops the transaction
        req0_ctrl    = 1'b0; req0_op1 = 8'd9; req0_op2 = 8'd4;
        req_valid    = 2'b01;
        resp_ready   = 1'b1;
        waited       = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready[0]) break;
            waited++;
            if (waited > 10) begin
                chk("rst_exec_accept_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #2 chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Five grants to requester 0 after reset (counter saturates at 3 when enabled)
        for (int i = 0; i < 5; i++) q0.push_back('{1'b0, DW'(i + 1), 8'd1});
        run(0);
`ifdef ALU_ARB_STATS_EN
        @(negedge clk);
        #2 chk("grant_cnt0_sat", 32'(grant_cnt0), 32'd3);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
